// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes (common with the
// control decoder), FSM states and the byte-lane mask helper.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  localparam logic [2:0] ST_SB = 3'd0;
  localparam logic [2:0] ST_SH = 3'd1;
  localparam logic [2:0] ST_SW = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  // 8-lane mask spanning two words; size_code 0/1/2 = 1/2/4 bytes
  function automatic logic [7:0] lsu_byte_mask(input logic [1:0] size_code,
                                               input logic [1:0] offset);
    logic [7:0] base;
    case (size_code)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Aligns the captured {beat1, beat0} read data by the byte offset and
// sign/zero-extends it according to the load width code.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_width,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = 32'(i_data >> {i_offset, 3'b000});
    case (i_width)
      LD_LB:   o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LD_LH:   o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LD_LBU:  o_result = {24'h0, w_shifted[7:0]};
      LD_LHU:  o_result = {16'h0, w_shifted[15:0]};
      default: o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs decoder memory requests as one or two word-wide
// req/ack bus beats, splitting misaligned accesses, and stalls the core meanwhile.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read_en,
  input  logic            mem_write_en,
  input  logic [2:0]      load_width,
  input  logic [2:0]      store_width,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  lsu_state_t r_state, w_next_state;

  logic [XLEN-1:0] r_word_addr;
  logic [1:0]      r_offset;
  logic [2:0]      r_lwidth;
  logic            r_is_load;
  logic            r_split;
  logic [3:0]      r_be_hi;
  logic [XLEN-1:0] r_wdata_hi;
  logic [XLEN-1:0] r_beat0;

  logic            r_bus_req;
  logic            r_bus_we;
  logic [XLEN-1:0] r_bus_addr;
  logic [3:0]      r_bus_be;
  logic [XLEN-1:0] r_bus_wdata;
  logic [XLEN-1:0] r_rdata;

  logic            w_legal_lw, w_legal_sw, w_legal, w_illegal;
  logic [1:0]      w_size_code;
  logic [7:0]      w_mask;
  logic [63:0]     w_wdata64;
  logic            w_ack;
  logic [63:0]     w_ld_data;
  logic [XLEN-1:0] w_ld_result;
  logic            w_stall, w_fault;

  // Request decode, lane mask and store lane alignment
  always_comb begin
    w_legal_lw  = load_width inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};
    w_legal_sw  = store_width inside {ST_SB, ST_SH, ST_SW};
    w_legal     = (mem_read_en ^ mem_write_en) &&
                  (mem_read_en ? w_legal_lw : w_legal_sw);
    w_illegal   = (mem_read_en && mem_write_en) ||
                  (mem_read_en && !w_legal_lw) ||
                  (mem_write_en && !w_legal_sw);
    w_size_code = mem_read_en ? load_width[1:0] : store_width[1:0];
    w_mask      = lsu_byte_mask(w_size_code, addr[1:0]);
    w_wdata64   = {32'h0, wdata} << {addr[1:0], 3'b000};
    w_ack       = bus_ack && r_bus_req;
    w_ld_data   = (r_state == BEAT1) ? {bus_rdata, r_beat0} : {32'h0, bus_rdata};
  end

  lsu_load_extend u_load_extend (
    .i_data   (w_ld_data),
    .i_offset (r_offset),
    .i_width  (r_lwidth),
    .o_result (w_ld_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_legal) w_next_state = BEAT0;
      BEAT0:   if (w_ack) w_next_state = r_split ? BEAT1 : DONE;
      BEAT1:   if (w_ack) w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Core-facing handshake; forced low while reset is held
  always_comb begin
    w_stall = 1'b0;
    w_fault = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          w_stall = w_legal;
          w_fault = w_illegal;
        end
        BEAT0, BEAT1: w_stall = 1'b1;
        default: ;
      endcase
    end
  end

  // Captured request, bus beat registers and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_addr <= '0;
      r_offset    <= '0;
      r_lwidth    <= '0;
      r_is_load   <= 1'b0;
      r_split     <= 1'b0;
      r_be_hi     <= '0;
      r_wdata_hi  <= '0;
      r_beat0     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_legal) begin
            r_word_addr <= {addr[XLEN-1:2], 2'b00};
            r_offset    <= addr[1:0];
            r_lwidth    <= load_width;
            r_is_load   <= mem_read_en;
            r_split     <= |w_mask[7:4];
            r_be_hi     <= w_mask[7:4];
            r_wdata_hi  <= mem_write_en ? w_wdata64[63:32] : '0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_write_en;
            r_bus_addr  <= {addr[XLEN-1:2], 2'b00};
            r_bus_be    <= w_mask[3:0];
            r_bus_wdata <= mem_write_en ? w_wdata64[31:0] : '0;
          end
        end
        BEAT0: begin
          if (w_ack) begin
            r_beat0 <= bus_rdata;
            if (r_split) begin
              r_bus_addr  <= r_word_addr + 32'd4;
              r_bus_be    <= r_be_hi;
              r_bus_wdata <= r_wdata_hi;
            end else begin
              r_bus_req   <= 1'b0;
              r_bus_we    <= 1'b0;
              r_bus_addr  <= '0;
              r_bus_be    <= '0;
              r_bus_wdata <= '0;
              if (r_is_load) r_rdata <= w_ld_result;
            end
          end
        end
        BEAT1: begin
          if (w_ack) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            if (r_is_load) r_rdata <= w_ld_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign stall     = w_stall;
  assign fault     = w_fault;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a responsive bus model
// and hand-written sequences for idle ack, illegal requests and mid-beat reset.
module tb_load_store_unit;

  logic        clk, rst;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  load_width, store_width;
  logic [31:0] addr, wdata, rdata;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata = 32'h0;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .load_width(load_width), .store_width(store_width),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  lw, sw;
    logic [31:0] addr, wdata, rd0, rd1;
    logic        split;
    logic [31:0] addr0; logic [3:0] be0; logic [31:0] wd0;
    logic [31:0] addr1; logic [3:0] be1; logic [31:0] wd1;
    logic [31:0] rdata;
    int          waits;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] w,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] r0, input logic [31:0] r1,
                              input logic sp,
                              input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                              input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1,
                              input logic [31:0] er, input int wt);
    vec_t v;
    v.rd = rd; v.wr = wr;
    v.lw = rd ? w : 3'd0; v.sw = wr ? w : 3'd0;
    v.addr = a; v.wdata = wd; v.rd0 = r0; v.rd1 = r1; v.split = sp;
    v.addr0 = a0; v.be0 = b0; v.wd0 = w0;
    v.addr1 = a1; v.be1 = b1; v.wd1 = w1;
    v.rdata = er; v.waits = wt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request and answer each beat after v.waits wait cycles
  task automatic run_vec(input vec_t v);
    int beat, wcnt, stall_cnt, exp_beats;
    logic done;
    exp_beats = v.split ? 2 : 1;
    @(posedge clk); #1;
    mem_read_en = v.rd; mem_write_en = v.wr;
    load_width = v.lw; store_width = v.sw;
    addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    chk("req_stall", 32'(stall), 32'd1);
    stall_cnt = 1; beat = 0; wcnt = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      mem_read_en = 1'b0; mem_write_en = 1'b0;
      addr = 32'h0BAD_0000; wdata = 32'hFFFF_FFFF;
      if (bus_req) begin
        chk("bus_we",    32'(bus_we), 32'(v.wr));
        chk("bus_addr",  bus_addr,  (beat == 0) ? v.addr0 : v.addr1);
        chk("bus_be",    32'(bus_be), 32'((beat == 0) ? v.be0 : v.be1));
        chk("bus_wdata", bus_wdata, (beat == 0) ? v.wd0 : v.wd1);
        bus_rdata = (beat == 0) ? v.rd0 : v.rd1;
        bus_ack   = (wcnt == v.waits);
        if (wcnt == v.waits) begin beat++; wcnt = 0; end
        else wcnt++;
      end else begin
        bus_ack = 1'b0;
        done = 1'b1;
        chk("beats", 32'(beat), 32'(exp_beats));
        if (v.rd) last_rdata = v.rdata;
        chk("rdata", rdata, last_rdata);
      end
      @(negedge clk);
      if (stall) stall_cnt++;
    end
    bus_ack = 1'b0;
    chk("done_within_budget", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stall_cnt), 32'(1 + exp_beats * (1 + v.waits)));
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = mk(0,1,3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0,
                  32'h100, 4'hF, 32'hDEADBEEF, 0, 4'h0, 0, 0, 0);
    vecs[1]  = mk(1,0,3'd0, 32'h103, 0, 32'h80112233, 0, 0,
                  32'h100, 4'h8, 0, 0, 4'h0, 0, 32'hFFFFFF80, 0);
    vecs[2]  = mk(1,0,3'd4, 32'h103, 0, 32'h80112233, 0, 0,
                  32'h100, 4'h8, 0, 0, 4'h0, 0, 32'h00000080, 0);
    vecs[3]  = mk(1,0,3'd2, 32'h102, 0, 32'h44332211, 32'h88776655, 1,
                  32'h100, 4'hC, 0, 32'h104, 4'h3, 0, 32'h66554433, 0);
    vecs[4]  = mk(0,1,3'd1, 32'h203, 32'h0000BEEF, 0, 0, 1,
                  32'h200, 4'h8, 32'hEF000000, 32'h204, 4'h1, 32'h000000BE, 0, 0);
    vecs[5]  = mk(1,0,3'd1, 32'hFFFFFFFF, 0, 32'h12000000, 32'h000000F0, 1,
                  32'hFFFFFFFC, 4'h8, 0, 32'h0, 4'h1, 0, 32'hFFFFF012, 0);
    vecs[6]  = mk(1,0,3'd5, 32'h101, 0, 32'hCAFEBABE, 0, 0,
                  32'h100, 4'h6, 0, 0, 4'h0, 0, 32'h0000FEBA, 0);
    vecs[7]  = mk(1,0,3'd2, 32'h40, 0, 32'h89ABCDEF, 0, 0,
                  32'h40, 4'hF, 0, 0, 4'h0, 0, 32'h89ABCDEF, 3);
    vecs[8]  = mk(0,1,3'd0, 32'h7, 32'h12345678, 0, 0, 0,
                  32'h4, 4'h8, 32'h78000000, 0, 4'h0, 0, 0, 0);
    vecs[9]  = mk(1,0,3'd1, 32'h2, 0, 32'h80011234, 0, 0,
                  32'h0, 4'hC, 0, 0, 4'h0, 0, 32'hFFFF8001, 0);
    vecs[10] = mk(0,1,3'd2, 32'h1, 32'hAABBCCDD, 0, 0, 1,
                  32'h0, 4'hE, 32'hBBCCDD00, 32'h4, 4'h1, 32'h000000AA, 0, 1);

    rst = 1'b1;
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    load_width = 3'd0; store_width = 3'd0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req",   32'(bus_req), 32'd0);
    chk("rst_bus_we",    32'(bus_we), 32'd0);
    chk("rst_bus_addr",  bus_addr, 32'd0);
    chk("rst_bus_be",    32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata",     rdata, 32'd0);
    chk("rst_stall",     32'(stall), 32'd0);
    chk("rst_fault",     32'(fault), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Stray ack while idle must be ignored
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_bus_req", 32'(bus_req), 32'd0);
    chk("stray_stall",   32'(stall), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("stray_bus_req2", 32'(bus_req), 32'd0);
    chk("stray_rdata",    rdata, last_rdata);

    // Illegal load width
    @(posedge clk); #1;
    mem_read_en = 1'b1; load_width = 3'd3; addr = 32'h100;
    @(negedge clk);
    chk("ill_lw_fault", 32'(fault), 32'd1);
    chk("ill_lw_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("ill_lw_no_req", 32'(bus_req), 32'd0);
    mem_read_en = 1'b0; load_width = 3'd0;
    @(negedge clk);
    chk("ill_lw_fault_end", 32'(fault), 32'd0);
    chk("ill_lw_no_req2",   32'(bus_req), 32'd0);

    // Both enables set
    @(posedge clk); #1;
    mem_read_en = 1'b1; mem_write_en = 1'b1; load_width = 3'd2; store_width = 3'd2;
    @(negedge clk);
    chk("ill_both_fault", 32'(fault), 32'd1);
    chk("ill_both_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("ill_both_no_req", 32'(bus_req), 32'd0);
    mem_read_en = 1'b0; mem_write_en = 1'b0;

    // Illegal store width
    @(posedge clk); #1;
    mem_write_en = 1'b1; store_width = 3'd5;
    @(negedge clk);
    chk("ill_sw_fault", 32'(fault), 32'd1);
    @(posedge clk); #1;
    chk("ill_sw_no_req", 32'(bus_req), 32'd0);
    mem_write_en = 1'b0; store_width = 3'd0;

    // Reset asserted during BEAT1 of a split load
    @(posedge clk); #1;
    mem_read_en = 1'b1; load_width = 3'd2; addr = 32'h102;
    @(posedge clk); #1;
    mem_read_en = 1'b0;
    chk("rb_beat0_req",  32'(bus_req), 32'd1);
    chk("rb_beat0_addr", bus_addr, 32'h100);
    bus_ack = 1'b1; bus_rdata = 32'h44332211;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("rb_beat1_req",  32'(bus_req), 32'd1);
    chk("rb_beat1_addr", bus_addr, 32'h104);
    #2;
    rst = 1'b1;
    #1;
    chk("rb_req_drop",  32'(bus_req), 32'd0);
    chk("rb_stall",     32'(stall), 32'd0);
    chk("rb_addr_clr",  bus_addr, 32'd0);
    chk("rb_rdata_clr", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rdata = 32'h0;
    bus_ack = 1'b1; bus_rdata = 32'h88776655;
    @(negedge clk);
    chk("rb_stray_req",   32'(bus_req), 32'd0);
    chk("rb_stray_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rb_idle_req",   32'(bus_req), 32'd0);
    chk("rb_idle_rdata", rdata, 32'd0);

    run_vec(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
